// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, redirect input, and
// the valid/ready instruction handoff to decode.
interface fetch_unit_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 8
);
   logic             mem_rden;
   logic [AW-1:0]    mem_rdaddress;
   logic [WIDTH-1:0] mem_q;
   logic             redirect;
   logic [AW-1:0]    redirect_pc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_instr;
   logic [AW-1:0]    out_pc;

   modport master (
      output mem_rden, mem_rdaddress,
      input  mem_q,
      input  redirect, redirect_pc,
      output out_valid, out_instr, out_pc,
      input  out_ready
   );

   modport slave (
      input  mem_rden, mem_rdaddress,
      output mem_q,
      output redirect, redirect_pc,
      input  out_valid, out_instr, out_pc,
      output out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, absorbs the 1-cycle memory read latency and
// feeds decode through a 2-entry {instr, pc} buffer; redirects flush everything.
module fetch_unit #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 256,
   parameter int RESET_PC = 0
) (
   input  logic         clock,
   input  logic         reset,
   fetch_unit_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PC_INIT = AW'(RESET_PC);
   localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

   logic [AW-1:0]    pc;
   logic [AW-1:0]    pc_inc;
   logic [AW-1:0]    pending_pc;
   logic             pending;
   logic             squash;
   logic [1:0]       count;
   logic [WIDTH-1:0] head_instr;
   logic [WIDTH-1:0] tail_instr;
   logic [AW-1:0]    head_pc;
   logic [AW-1:0]    tail_pc;
   logic             pop;
   logic             push;
   logic             issue;
   logic             push_to_head;
   logic [2:0]       occupancy;

   // A read is only issued if its return is guaranteed a buffer slot.
   always_comb begin
      pop          = (count != 2'd0) && bus.out_ready;
      push         = pending && !squash && !bus.redirect;
      occupancy    = 3'(count) + 3'(pending) - 3'(pop);
      issue        = !reset && !bus.redirect && (occupancy < 3'd2);
      pc_inc       = (pc == PC_LAST) ? '0 : pc + AW'(1);
      push_to_head = (count == 2'd0) || ((count == 2'd1) && pop);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc         <= PC_INIT;
         pending_pc <= '0;
         pending    <= 1'b0;
         squash     <= 1'b0;
         count      <= '0;
      end else begin
         pending <= issue;
         squash  <= bus.redirect && pending;
         if (bus.redirect) begin
            pc    <= bus.redirect_pc;
            count <= '0;
         end else begin
            if (issue) begin
               pending_pc <= pc;
               pc         <= pc_inc;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
         end
      end
   end

   // Head always holds the oldest entry so out_instr/out_pc come straight from flops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_instr <= '0;
         head_pc    <= '0;
         tail_instr <= '0;
         tail_pc    <= '0;
      end else begin
         if (pop) begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
         end
         if (push) begin
            if (push_to_head) begin
               head_instr <= bus.mem_q;
               head_pc    <= pending_pc;
            end else begin
               tail_instr <= bus.mem_q;
               tail_pc    <= pending_pc;
            end
         end
      end
   end

   no_overflow: assert property (@(posedge clock) disable iff (reset)
      !(push && !pop && (count == 2'd2)));

   assign bus.mem_rden      = issue;
   assign bus.mem_rdaddress = pc;
   assign bus.out_valid     = (count != 2'd0);
   assign bus.out_instr     = head_instr;
   assign bus.out_pc        = head_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0 and 254), each
// backed by a registered-read memory model holding word i = 0x1000 + i.
module tb_fetch_unit;
   logic clock;
   logic reset;
   logic rst_w;
   int   tests = 0;
   int   fails = 0;

   fetch_unit_if #(.WIDTH(32), .AW(8)) bus0 ();
   fetch_unit_if #(.WIDTH(32), .AW(8)) bus1 ();

   fetch_unit #(.WIDTH(32), .DEPTH(256), .RESET_PC(0)) dut0 (
      .clock(clock), .reset(reset), .bus(bus0));
   fetch_unit #(.WIDTH(32), .DEPTH(256), .RESET_PC(254)) dut1 (
      .clock(clock), .reset(rst_w), .bus(bus1));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) if (bus0.mem_rden) bus0.mem_q <= 32'h1000 + 32'(bus0.mem_rdaddress);
   always @(posedge clock) if (bus1.mem_rden) bus1.mem_q <= 32'h1000 + 32'(bus1.mem_rdaddress);

   logic [40:0] obs0, obs1;
   assign obs0 = {bus0.out_valid, bus0.out_pc, bus0.out_instr};
   assign obs1 = {bus1.out_valid, bus1.out_pc, bus1.out_instr};

   function automatic logic [40:0] ov(input logic v, input logic [7:0] p, input logic [31:0] i);
      return {v, p, i};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; rst_w = 1'b1;
      bus0.out_ready = 1'b1; bus0.redirect = 1'b0; bus0.redirect_pc = '0;
      bus1.out_ready = 1'b1; bus1.redirect = 1'b0; bus1.redirect_pc = '0;
      tick(); tick();
      tests++; if (obs0 !== ov(1'b0, 8'h00, 32'h0)) begin fails++; $display("FAIL reset_out: got %h want %h", obs0, ov(1'b0, 8'h00, 32'h0)); end
      tests++; if (bus0.mem_rden !== 1'b0) begin fails++; $display("FAIL reset_rden: got %b want 0", bus0.mem_rden); end
      tests++; if (bus0.mem_rdaddress !== 8'h00) begin fails++; $display("FAIL reset_addr: got %h want 00", bus0.mem_rdaddress); end
   endtask

   task automatic test_sequential();
      reset = 1'b0;
      #1;
      tests++; if ({bus0.mem_rden, bus0.mem_rdaddress} !== {1'b1, 8'h00}) begin fails++; $display("FAIL seq_first_issue: got %b/%h want 1/00", bus0.mem_rden, bus0.mem_rdaddress); end
      tests++; if (bus0.out_valid !== 1'b0) begin fails++; $display("FAIL seq_lat0: got %b want 0", bus0.out_valid); end
      tick();
      tests++; if (bus0.out_valid !== 1'b0) begin fails++; $display("FAIL seq_lat1: got %b want 0", bus0.out_valid); end
      tests++; if ({bus0.mem_rden, bus0.mem_rdaddress} !== {1'b1, 8'h01}) begin fails++; $display("FAIL seq_second_issue: got %b/%h want 1/01", bus0.mem_rden, bus0.mem_rdaddress); end
      for (int k = 0; k < 5; k++) begin
         tick();
         tests++; if (obs0 !== ov(1'b1, 8'(k), 32'h1000 + 32'(k))) begin fails++; $display("FAIL seq_out%0d: got %h want %h", k, obs0, ov(1'b1, 8'(k), 32'h1000 + 32'(k))); end
      end
   endtask

   task automatic test_backpressure();
      tick();
      tests++; if (obs0 !== ov(1'b1, 8'h05, 32'h1005)) begin fails++; $display("FAIL bp_start: got %h want %h", obs0, ov(1'b1, 8'h05, 32'h1005)); end
      bus0.out_ready = 1'b0;
      #1;
      tests++; if (bus0.mem_rden !== 1'b0) begin fails++; $display("FAIL bp_rden_drop: got %b want 0", bus0.mem_rden); end
      for (int i = 1; i < 5; i++) begin
         tick();
         tests++; if (obs0 !== ov(1'b1, 8'h05, 32'h1005)) begin fails++; $display("FAIL bp_hold%0d: got %h want %h", i, obs0, ov(1'b1, 8'h05, 32'h1005)); end
         tests++; if (bus0.mem_rden !== 1'b0) begin fails++; $display("FAIL bp_rden%0d: got %b want 0", i, bus0.mem_rden); end
      end
      tick();
      tests++; if (obs0 !== ov(1'b1, 8'h05, 32'h1005)) begin fails++; $display("FAIL bp_hold5: got %h want %h", obs0, ov(1'b1, 8'h05, 32'h1005)); end
      bus0.out_ready = 1'b1;
      #1;
      tests++; if ({bus0.mem_rden, bus0.mem_rdaddress} !== {1'b1, 8'h07}) begin fails++; $display("FAIL bp_resume_issue: got %b/%h want 1/07", bus0.mem_rden, bus0.mem_rdaddress); end
      for (int k = 6; k < 10; k++) begin
         tick();
         tests++; if (obs0 !== ov(1'b1, 8'(k), 32'h1000 + 32'(k))) begin fails++; $display("FAIL bp_after%0d: got %h want %h", k, obs0, ov(1'b1, 8'(k), 32'h1000 + 32'(k))); end
      end
   endtask

   task automatic test_redirect();
      tick();
      tests++; if (obs0 !== ov(1'b1, 8'h0a, 32'h100a)) begin fails++; $display("FAIL rd_pre: got %h want %h", obs0, ov(1'b1, 8'h0a, 32'h100a)); end
      bus0.redirect = 1'b1; bus0.redirect_pc = 8'h40; bus0.out_ready = 1'b0;
      #1;
      tests++; if (bus0.mem_rden !== 1'b0) begin fails++; $display("FAIL rd_no_issue: got %b want 0", bus0.mem_rden); end
      tick();
      bus0.redirect = 1'b0; bus0.out_ready = 1'b1;
      #1;
      tests++; if (bus0.out_valid !== 1'b0) begin fails++; $display("FAIL rd_gap1: got %b want 0", bus0.out_valid); end
      tests++; if ({bus0.mem_rden, bus0.mem_rdaddress} !== {1'b1, 8'h40}) begin fails++; $display("FAIL rd_issue: got %b/%h want 1/40", bus0.mem_rden, bus0.mem_rdaddress); end
      tick();
      tests++; if (bus0.out_valid !== 1'b0) begin fails++; $display("FAIL rd_gap2: got %b want 0", bus0.out_valid); end
      tick();
      tests++; if (obs0 !== ov(1'b1, 8'h40, 32'h1040)) begin fails++; $display("FAIL rd_out40: got %h want %h", obs0, ov(1'b1, 8'h40, 32'h1040)); end
      tick();
      tests++; if (obs0 !== ov(1'b1, 8'h41, 32'h1041)) begin fails++; $display("FAIL rd_out41: got %h want %h", obs0, ov(1'b1, 8'h41, 32'h1041)); end
   endtask

   task automatic test_redirect_accept();
      tick();
      tests++; if (obs0 !== ov(1'b1, 8'h42, 32'h1042)) begin fails++; $display("FAIL rda_pre: got %h want %h", obs0, ov(1'b1, 8'h42, 32'h1042)); end
      bus0.redirect = 1'b1; bus0.redirect_pc = 8'h80;
      tick();
      bus0.redirect = 1'b0;
      tests++; if (bus0.out_valid !== 1'b0) begin fails++; $display("FAIL rda_gap1: got %b want 0", bus0.out_valid); end
      tick();
      tests++; if (bus0.out_valid !== 1'b0) begin fails++; $display("FAIL rda_gap2: got %b want 0", bus0.out_valid); end
      tick();
      tests++; if (obs0 !== ov(1'b1, 8'h80, 32'h1080)) begin fails++; $display("FAIL rda_out80: got %h want %h", obs0, ov(1'b1, 8'h80, 32'h1080)); end
      tick();
      tests++; if (obs0 !== ov(1'b1, 8'h81, 32'h1081)) begin fails++; $display("FAIL rda_out81: got %h want %h", obs0, ov(1'b1, 8'h81, 32'h1081)); end
   endtask

   task automatic test_back_to_back_redirect();
      tick();
      bus0.redirect = 1'b1; bus0.redirect_pc = 8'h10;
      tick();
      bus0.redirect_pc = 8'h20;
      tick();
      bus0.redirect = 1'b0;
      tests++; if (bus0.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_gap1: got %b want 0", bus0.out_valid); end
      tick();
      tests++; if (bus0.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_gap2: got %b want 0", bus0.out_valid); end
      tick();
      tests++; if (obs0 !== ov(1'b1, 8'h20, 32'h1020)) begin fails++; $display("FAIL b2b_out20: got %h want %h", obs0, ov(1'b1, 8'h20, 32'h1020)); end
      tick();
      tests++; if (obs0 !== ov(1'b1, 8'h21, 32'h1021)) begin fails++; $display("FAIL b2b_out21: got %h want %h", obs0, ov(1'b1, 8'h21, 32'h1021)); end
   endtask

   task automatic test_reset_midop();
      bus0.out_ready = 1'b0;
      tick();
      tests++; if (obs0 !== ov(1'b1, 8'h21, 32'h1021)) begin fails++; $display("FAIL rst_held: got %h want %h", obs0, ov(1'b1, 8'h21, 32'h1021)); end
      #2 reset = 1'b1;
      #1;
      tests++; if (obs0 !== ov(1'b0, 8'h00, 32'h0)) begin fails++; $display("FAIL rst_async_out: got %h want %h", obs0, ov(1'b0, 8'h00, 32'h0)); end
      tests++; if (bus0.mem_rden !== 1'b0) begin fails++; $display("FAIL rst_async_rden: got %b want 0", bus0.mem_rden); end
      tick();
      tests++; if ({bus0.mem_rden, bus0.mem_rdaddress} !== {1'b0, 8'h00}) begin fails++; $display("FAIL rst_hold: got %b/%h want 0/00", bus0.mem_rden, bus0.mem_rdaddress); end
      reset = 1'b0; bus0.out_ready = 1'b1;
      #1;
      tests++; if ({bus0.mem_rden, bus0.mem_rdaddress} !== {1'b1, 8'h00}) begin fails++; $display("FAIL rst_restart_issue: got %b/%h want 1/00", bus0.mem_rden, bus0.mem_rdaddress); end
      tick();
      tests++; if (bus0.out_valid !== 1'b0) begin fails++; $display("FAIL rst_lat: got %b want 0", bus0.out_valid); end
      tick();
      tests++; if (obs0 !== ov(1'b1, 8'h00, 32'h1000)) begin fails++; $display("FAIL rst_out0: got %h want %h", obs0, ov(1'b1, 8'h00, 32'h1000)); end
      tick();
      tests++; if (obs0 !== ov(1'b1, 8'h01, 32'h1001)) begin fails++; $display("FAIL rst_out1: got %h want %h", obs0, ov(1'b1, 8'h01, 32'h1001)); end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_pc [4];
      exp_pc[0] = 8'hfe; exp_pc[1] = 8'hff; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
      rst_w = 1'b0;
      #1;
      tests++; if ({bus1.mem_rden, bus1.mem_rdaddress} !== {1'b1, 8'hfe}) begin fails++; $display("FAIL wrap_issue: got %b/%h want 1/fe", bus1.mem_rden, bus1.mem_rdaddress); end
      tick();
      tests++; if (bus1.out_valid !== 1'b0) begin fails++; $display("FAIL wrap_lat: got %b want 0", bus1.out_valid); end
      for (int k = 0; k < 4; k++) begin
         tick();
         tests++; if (obs1 !== ov(1'b1, exp_pc[k], 32'h1000 + 32'(exp_pc[k]))) begin fails++; $display("FAIL wrap_out%0d: got %h want %h", k, obs1, ov(1'b1, exp_pc[k], 32'h1000 + 32'(exp_pc[k]))); end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect();
      test_redirect_accept();
      test_back_to_back_redirect();
      test_reset_midop();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
